instruction_dispatcher: RTL and testbench
=========================================

INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: WAIT_DONE cycles before abort (1..255).
REQ-002 SHALL have port clk, input, 1: single clock; every flop on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: decoded instruction present.
REQ-005 SHALL have port in_ready, output, 1: dispatcher accepts this cycle.
REQ-006 SHALL have port in_ctrl, input, control_signal_t: decoded fields unit_id[1:0], op_code, comp_type, addr[3:0], valid, size[2:0].
REQ-007 SHALL have port in_error, input, 1: decoder flagged the instruction invalid.
REQ-008 SHALL have port unit_req, output, 4: one-hot beat request per unit.
REQ-009 SHALL have port unit_op / unit_comp / unit_addr, output, operation_code_t / computation_type_t / 4: beat payload.
REQ-010 SHALL have port unit_ack, input, 4: per-unit beat accept.
REQ-011 SHALL have port unit_done, input, 4: per-unit COMP completion.
REQ-012 SHALL have port busy, output, 1: state != IDLE.
REQ-013 SHALL have port issued_cnt, output, 16: count of instructions fully dispatched, wrapping.
REQ-014 SHALL have port dropped_cnt, output, 8: count of in_error instructions, saturating at 255.
REQ-015 SHALL have port timeout_flag, output, 1: sticky; set on watchdog abort.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE; in_ready = (state==IDLE).
REQ-017 Accept = in_valid && in_ready; on accept, SHALL latch in_ctrl, load beat counter with size, load addr register with addr.
REQ-018 Accepted with in_error=1: SHALL stay IDLE, increment dropped_cnt (saturating), issue nothing.
REQ-019 Accepted OP_NOP (no error): SHALL stay IDLE, increment issued_cnt, issue nothing.
REQ-020 Accepted OP_LOAD/OP_STORE/OP_COMP (no error): SHALL enter ISSUE next cycle.
REQ-021 In ISSUE: unit_req[unit_id]=1, others 0; payload from latched fields; payload held stable until ack.
REQ-022 A beat completes on unit_req[u] && unit_ack[u]; SHALL increment addr modulo 16 (15 wraps to 0), decrement beat counter.
REQ-023 LOAD/STORE SHALL issue size+1 beats (1..8); after the last beat, return to IDLE and increment issued_cnt.
REQ-024 COMP SHALL issue exactly one beat regardless of size, then enter WAIT_DONE.
REQ-025 In WAIT_DONE: unit_req=0; on unit_done[unit_id], return to IDLE and increment issued_cnt; done from other units is ignored.
REQ-026 unit_done SHALL be sampled only in WAIT_DONE; done coincident with the COMP ack beat is ignored.
REQ-027 Watchdog SHALL count WAIT_DONE cycles; at TIMEOUT_CYCLES without done, go to IDLE, set timeout_flag, leave issued_cnt unchanged.
REQ-028 unit_ack for non-targeted units, or while not in ISSUE, SHALL be ignored.
REQ-029 Back-to-back acceptance SHALL be possible every cycle while NOP/error instructions keep the FSM in IDLE.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, unit_req=0, unit_op=OP_NOP, unit_comp=COMP_ADD, unit_addr=0, busy=0, issued_cnt=0, dropped_cnt=0, timeout_flag=0, watchdog=0.
REQ-031 Reset mid-ISSUE or mid-WAIT_DONE SHALL abort the instruction; unit_req deasserts the cycle after the reset edge.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 control_signal_t, operation_code_t and computation_type_t SHALL come from accel_pkg; NUM_UNITS=4 and DISPATCH_TIMEOUT_DEFAULT=255 SHALL be added to accel_pkg.
REQ-034 The watchdog SHALL be a sub-module dispatch_watchdog (inputs: enable, clear; output: expired).

Verification
REQ-035 LOAD unit 2, addr 14, size 3, ack always 1 -> 4 beats on unit_req=4'b0100, addrs 14,15,0,1; issued_cnt=1; in_ready high the cycle after the last beat.
REQ-036 COMP unit 1, done asserted 5 cycles after ack -> 1 beat, WAIT_DONE for 5 cycles, then IDLE; issued_cnt=1; unit_done[0] pulses during the wait ignored.
REQ-037 Three back-to-back NOPs, then an in_error instruction -> in_ready stays 1 throughout, issued_cnt=3, dropped_cnt=1, unit_req never asserted.
REQ-038 STORE size 7, ack toggling 1/0 -> exactly 8 beats, payload stable while ack=0.
REQ-039 COMP with done never asserted, TIMEOUT_CYCLES=10 -> IDLE after 10 WAIT_DONE cycles, timeout_flag=1, issued_cnt unchanged.
REQ-040 rst pulsed during the 3rd beat of a size-5 LOAD -> unit_req=0 and all counters 0 the next cycle, in_ready=1 after release.

Source files
------------

// File: rtl/accel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accel_pkg: shared types and constants for the accelerator front end  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package accel_pkg;

  localparam int NUM_UNITS                = 4;
  localparam int DISPATCH_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_COMP  = 2'd3
  } operation_code_t;

  typedef enum logic [1:0] {
    COMP_ADD = 2'd0,
    COMP_SUB = 2'd1,
    COMP_MUL = 2'd2,
    COMP_MAX = 2'd3
  } computation_type_t;

  typedef struct packed {
    logic [1:0]        unit_id;
    operation_code_t   op_code;
    computation_type_t comp_type;
    logic [3:0]        addr;
    logic              valid;
    logic [2:0]        size;
  } control_signal_t;

  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [1:0] id);
    logic [NUM_UNITS-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dispatch_watchdog: counts enabled cycles, flags the last allowed one |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dispatch_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] c_last_count = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Asserted during the TIMEOUT_CYCLES-th enabled cycle, so the abort lands on its closing edge.
  assign expired = enable && (r_count == c_last_count);

endmodule
`default_nettype wire

// File: rtl/instruction_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_dispatcher: issues decoded instructions as unit beats    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_dispatcher
  import accel_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DISPATCH_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  control_signal_t      in_ctrl,
  input  logic                 in_error,
  output logic [NUM_UNITS-1:0] unit_req,
  output operation_code_t      unit_op,
  output computation_type_t    unit_comp,
  output logic [3:0]           unit_addr,
  input  logic [NUM_UNITS-1:0] unit_ack,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic [15:0]          issued_cnt,
  output logic [7:0]           dropped_cnt,
  output logic                 timeout_flag
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [1:0]           r_unit_id;
  operation_code_t      r_op;
  computation_type_t    r_comp;
  logic [3:0]           r_addr;
  logic [2:0]           r_beats;
  logic [NUM_UNITS-1:0] r_req;
  logic [15:0]          r_issued;
  logic [7:0]           r_dropped;
  logic                 r_timeout;

  logic w_accept;
  logic w_beat_done;
  logic w_last_beat;
  logic w_in_wait;
  logic w_target_done;
  logic w_wd_clear;
  logic w_expired;
  logic w_unused;

  assign w_accept      = in_valid && (r_state == ST_IDLE);
  assign w_beat_done   = (r_state == ST_ISSUE) && (|(r_req & unit_ack));
  assign w_last_beat   = (r_op == OP_COMP) || (r_beats == 3'd0);
  assign w_in_wait     = (r_state == ST_WAIT_DONE);
  assign w_target_done = w_in_wait && unit_done[r_unit_id];
  assign w_wd_clear    = !w_in_wait;
  assign w_unused      = in_ctrl.valid;

  dispatch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (w_in_wait),
    .clear  (w_wd_clear),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_unit_id <= '0;
      r_op      <= OP_NOP;
      r_comp    <= COMP_ADD;
      r_addr    <= '0;
      r_beats   <= '0;
      r_req     <= '0;
      r_issued  <= '0;
      r_dropped <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_unit_id <= in_ctrl.unit_id;
            r_op      <= in_ctrl.op_code;
            r_comp    <= in_ctrl.comp_type;
            r_addr    <= in_ctrl.addr;
            r_beats   <= in_ctrl.size;
            if (in_error) begin
              if (r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
            end else if (in_ctrl.op_code == OP_NOP) begin
              r_issued <= r_issued + 16'd1;
            end else begin
              r_state <= ST_ISSUE;
              r_req   <= unit_onehot(in_ctrl.unit_id);
            end
          end
        end
        ST_ISSUE: begin
          if (w_beat_done) begin
            r_addr  <= r_addr + 4'd1;
            r_beats <= r_beats - 3'd1;
            if (w_last_beat) begin
              r_req <= '0;
              if (r_op == OP_COMP) begin
                r_state <= ST_WAIT_DONE;
              end else begin
                r_state  <= ST_IDLE;
                r_issued <= r_issued + 16'd1;
              end
            end
          end
        end
        ST_WAIT_DONE: begin
          // A completion arriving on the expiry cycle still counts as a successful dispatch.
          if (w_target_done) begin
            r_state  <= ST_IDLE;
            r_issued <= r_issued + 16'd1;
          end else if (w_expired) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign unit_req     = r_req;
  assign unit_op      = r_op;
  assign unit_comp    = r_comp;
  assign unit_addr    = r_addr;
  assign issued_cnt   = r_issued;
  assign dropped_cnt  = r_dropped;
  assign timeout_flag = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_instruction_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_instruction_dispatcher: scenario tasks plus randomized model run  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instruction_dispatcher;
  import accel_pkg::*;

  localparam int TO = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  control_signal_t   in_ctrl;
  logic              in_error;
  logic [3:0]        unit_req;
  operation_code_t   unit_op;
  computation_type_t unit_comp;
  logic [3:0]        unit_addr;
  logic [3:0]        unit_ack;
  logic [3:0]        unit_done;
  logic              busy;
  logic [15:0]       issued_cnt;
  logic [7:0]        dropped_cnt;
  logic              timeout_flag;

  instruction_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_error(in_error), .unit_req(unit_req),
    .unit_op(unit_op), .unit_comp(unit_comp), .unit_addr(unit_addr),
    .unit_ack(unit_ack), .unit_done(unit_done), .busy(busy),
    .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        req;
    operation_code_t   op;
    computation_type_t comp;
    logic [3:0]        addr;
  } beat_t;

  int    total = 0;
  int    bad   = 0;
  beat_t obs_q[$];
  int    stab_err, req_err, wait_cycles, n_cycles;
  logic  hung;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic control_signal_t mk(input logic [1:0] u, input operation_code_t op,
                                         input computation_type_t ct, input logic [3:0] a,
                                         input logic [2:0] s);
    control_signal_t c;
    c.unit_id = u; c.op_code = op; c.comp_type = ct; c.addr = a; c.valid = 1'b1; c.size = s;
    return c;
  endfunction

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; in_error = 1'b0; unit_ack = '0; unit_done = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Presents one instruction, then plays the unit side until the dispatcher is idle again.
  // ack_mode: 0 always, 1 toggling starting at 1, 2 random. done_delay 0 means never.
  task automatic drive_instr(input control_signal_t c, input logic err, input int ack_mode,
                             input int done_delay, input logic noise);
    logic [3:0] tgt;
    logic       ack_now, toggle, hold_valid;
    beat_t      held;
    obs_q.delete();
    stab_err = 0; req_err = 0; wait_cycles = 0; n_cycles = 0; hung = 1'b0;
    toggle = 1'b1; hold_valid = 1'b0; ack_now = 1'b0;
    tgt = 4'b0001 << c.unit_id;
    in_valid = 1'b1; in_ctrl = c; in_error = err;
    step();
    in_valid = 1'b0; in_error = 1'b0; in_ctrl = control_signal_t'(14'($urandom));
    while (busy === 1'b1 && n_cycles < 300) begin
      n_cycles++;
      unit_ack = '0; unit_done = '0;
      if (unit_req !== 4'b0000) begin
        if (unit_req !== tgt) req_err++;
        if (hold_valid && (held.addr !== unit_addr || held.op !== unit_op ||
                           held.comp !== unit_comp || held.req !== unit_req)) stab_err++;
        case (ack_mode)
          0:       ack_now = 1'b1;
          1:       begin ack_now = toggle; toggle = ~toggle; end
          default: ack_now = 1'($urandom_range(0, 1));
        endcase
        if (noise) unit_ack = 4'($urandom) & ~tgt;
        if (ack_now) unit_ack = unit_ack | tgt;
        if (noise && c.op_code == OP_COMP) unit_done = tgt;
        held.req = unit_req; held.op = unit_op; held.comp = unit_comp; held.addr = unit_addr;
        if (ack_now) begin
          obs_q.push_back(held);
          hold_valid = 1'b0;
        end else begin
          hold_valid = 1'b1;
        end
      end else begin
        wait_cycles++;
        if (noise) unit_done = 4'($urandom) & ~tgt;
        if (done_delay > 0 && wait_cycles == done_delay) unit_done = unit_done | tgt;
      end
      step();
    end
    unit_ack = '0; unit_done = '0;
    if (busy !== 1'b0) hung = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_error = 1'b0; unit_ack = '0; unit_done = '0; in_ctrl = '0;
    step();
    total++; if (unit_req !== 4'b0) begin bad++; $display("FAIL rst_req: got %b want 0000", unit_req); end
    total++; if (unit_op !== OP_NOP) begin bad++; $display("FAIL rst_op: got %0d want %0d", unit_op, OP_NOP); end
    total++; if (unit_comp !== COMP_ADD) begin bad++; $display("FAIL rst_comp: got %0d want %0d", unit_comp, COMP_ADD); end
    total++; if (unit_addr !== 4'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", unit_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (issued_cnt !== 16'd0) begin bad++; $display("FAIL rst_issued: got %0d want 0", issued_cnt); end
    total++; if (dropped_cnt !== 8'd0) begin bad++; $display("FAIL rst_dropped: got %0d want 0", dropped_cnt); end
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_flag); end
    rst = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_load_wrap();
    reset_dut();
    drive_instr(mk(2'd2, OP_LOAD, COMP_ADD, 4'd14, 3'd3), 1'b0, 0, 0, 1'b0);
    total++; if (hung !== 1'b0) begin bad++; $display("FAIL load_hung: got %b want 0", hung); end
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL load_beats: got %0d want 4", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < 4; k++) begin
      total++;
      if (obs_q[k].req !== 4'b0100 || obs_q[k].addr !== 4'((14 + k) % 16) || obs_q[k].op !== OP_LOAD) begin
        bad++;
        $display("FAIL load_beat%0d: got req=%b addr=%0d op=%0d want req=0100 addr=%0d op=%0d",
                 k, obs_q[k].req, obs_q[k].addr, obs_q[k].op, (14 + k) % 16, OP_LOAD);
      end
    end
    total++; if (n_cycles != 4) begin bad++; $display("FAIL load_latency: got %0d want 4", n_cycles); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL load_ready: got %b want 1", in_ready); end
    total++; if (issued_cnt !== 16'd1) begin bad++; $display("FAIL load_issued: got %0d want 1", issued_cnt); end
  endtask

  task automatic test_comp_wait();
    reset_dut();
    drive_instr(mk(2'd1, OP_COMP, COMP_MUL, 4'd5, 3'd6), 1'b0, 0, 5, 1'b1);
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL comp_beats: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      total++;
      if (obs_q[0].req !== 4'b0010 || obs_q[0].op !== OP_COMP || obs_q[0].comp !== COMP_MUL || obs_q[0].addr !== 4'd5) begin
        bad++;
        $display("FAIL comp_payload: got req=%b op=%0d comp=%0d addr=%0d want req=0010 op=3 comp=2 addr=5",
                 obs_q[0].req, obs_q[0].op, obs_q[0].comp, obs_q[0].addr);
      end
    end
    total++; if (wait_cycles != 5) begin bad++; $display("FAIL comp_wait: got %0d want 5", wait_cycles); end
    total++; if (issued_cnt !== 16'd1) begin bad++; $display("FAIL comp_issued: got %0d want 1", issued_cnt); end
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL comp_timeout: got %b want 0", timeout_flag); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
      in_valid = 1'b1;
      in_error = (i == 3);
      in_ctrl  = (i == 3) ? mk(2'($urandom), OP_LOAD, COMP_ADD, 4'd0, 3'd2)
                          : mk(2'($urandom), OP_NOP, COMP_SUB, 4'($urandom), 3'($urandom));
      step();
      total++; if (unit_req !== 4'b0) begin bad++; $display("FAIL b2b_req%0d: got %b want 0000", i, unit_req); end
    end
    in_valid = 1'b0; in_error = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_end: got %b want 1", in_ready); end
    total++; if (issued_cnt !== 16'd3) begin bad++; $display("FAIL b2b_issued: got %0d want 3", issued_cnt); end
    total++; if (dropped_cnt !== 8'd1) begin bad++; $display("FAIL b2b_dropped: got %0d want 1", dropped_cnt); end
  endtask

  task automatic test_store_toggle();
    reset_dut();
    drive_instr(mk(2'd3, OP_STORE, COMP_MAX, 4'd9, 3'd7), 1'b0, 1, 0, 1'b1);
    total++; if (obs_q.size() != 8) begin bad++; $display("FAIL store_beats: got %0d want 8", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      total++;
      if (obs_q[k].req !== 4'b1000 || obs_q[k].addr !== 4'((9 + k) % 16) || obs_q[k].op !== OP_STORE) begin
        bad++;
        $display("FAIL store_beat%0d: got req=%b addr=%0d op=%0d want req=1000 addr=%0d op=%0d",
                 k, obs_q[k].req, obs_q[k].addr, obs_q[k].op, (9 + k) % 16, OP_STORE);
      end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL store_stable: got %0d changes want 0", stab_err); end
    total++; if (n_cycles != 15) begin bad++; $display("FAIL store_cycles: got %0d want 15", n_cycles); end
    total++; if (issued_cnt !== 16'd1) begin bad++; $display("FAIL store_issued: got %0d want 1", issued_cnt); end
  endtask

  task automatic test_timeout();
    reset_dut();
    drive_instr(mk(2'd0, OP_COMP, COMP_SUB, 4'd3, 3'd2), 1'b0, 0, 0, 1'b1);
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL to_beats: got %0d want 1", obs_q.size()); end
    total++; if (wait_cycles != TO) begin bad++; $display("FAIL to_wait: got %0d want %0d", wait_cycles, TO); end
    total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", timeout_flag); end
    total++; if (issued_cnt !== 16'd0) begin bad++; $display("FAIL to_issued: got %0d want 0", issued_cnt); end
    drive_instr(mk(2'd1, OP_LOAD, COMP_ADD, 4'd0, 3'd0), 1'b0, 0, 0, 1'b0);
    total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_flag); end
    total++; if (issued_cnt !== 16'd1) begin bad++; $display("FAIL to_after_issued: got %0d want 1", issued_cnt); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive_instr(mk(2'd0, OP_NOP, COMP_ADD, 4'd0, 3'd0), 1'b0, 0, 0, 1'b0);
    drive_instr(mk(2'd0, OP_LOAD, COMP_ADD, 4'd0, 3'd0), 1'b1, 0, 0, 1'b0);
    in_valid = 1'b1; in_ctrl = mk(2'd0, OP_LOAD, COMP_ADD, 4'd0, 3'd5); in_error = 1'b0;
    step();
    in_valid = 1'b0;
    unit_ack = 4'b0001;
    step();
    step();
    total++; if (unit_addr !== 4'd2 || unit_req !== 4'b0001) begin
      bad++; $display("FAIL mid_third_beat: got req=%b addr=%0d want req=0001 addr=2", unit_req, unit_addr);
    end
    rst = 1'b1;
    step();
    total++; if (unit_req !== 4'b0) begin bad++; $display("FAIL mid_req: got %b want 0000", unit_req); end
    total++; if (issued_cnt !== 16'd0 || dropped_cnt !== 8'd0 || timeout_flag !== 1'b0) begin
      bad++; $display("FAIL mid_counters: got issued=%0d dropped=%0d to=%b want 0 0 0", issued_cnt, dropped_cnt, timeout_flag);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    rst = 1'b0; unit_ack = '0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_dropped_saturate();
    reset_dut();
    in_valid = 1'b1; in_error = 1'b1; in_ctrl = mk(2'd2, OP_STORE, COMP_ADD, 4'd1, 3'd1);
    for (int i = 0; i < 260; i++) begin
      step();
      if (i == 253) begin
        total++; if (dropped_cnt !== 8'd254) begin bad++; $display("FAIL drop_254: got %0d want 254", dropped_cnt); end
      end
    end
    in_valid = 1'b0; in_error = 1'b0;
    total++; if (dropped_cnt !== 8'd255) begin bad++; $display("FAIL drop_sat: got %0d want 255", dropped_cnt); end
    total++; if (issued_cnt !== 16'd0 || unit_req !== 4'b0) begin
      bad++; $display("FAIL drop_side: got issued=%0d req=%b want 0 0000", issued_cnt, unit_req);
    end
  endtask

  task automatic test_random();
    int              exp_issued, exp_dropped, exp_wait, done_delay, nbeats;
    logic            exp_to, err;
    control_signal_t c;
    beat_t           exp_q[$];
    beat_t           b;
    reset_dut();
    exp_issued = 0; exp_dropped = 0; exp_to = 1'b0;
    for (int n = 0; n < 60; n++) begin
      c = mk(2'($urandom), operation_code_t'($urandom_range(0, 3)),
             computation_type_t'($urandom_range(0, 3)), 4'($urandom), 3'($urandom));
      err        = ($urandom_range(0, 7) == 0);
      done_delay = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
      exp_q.delete();
      exp_wait = 0;
      if (err) begin
        exp_dropped = (exp_dropped < 255) ? exp_dropped + 1 : 255;
      end else if (c.op_code == OP_NOP) begin
        exp_issued++;
      end else begin
        nbeats = (c.op_code == OP_COMP) ? 1 : int'(c.size) + 1;
        for (int k = 0; k < nbeats; k++) begin
          b.req = 4'b0001 << c.unit_id; b.op = c.op_code; b.comp = c.comp_type;
          b.addr = 4'((int'(c.addr) + k) % 16);
          exp_q.push_back(b);
        end
        if (c.op_code != OP_COMP) exp_issued++;
        else if (done_delay > 0) begin exp_issued++; exp_wait = done_delay; end
        else begin exp_to = 1'b1; exp_wait = TO; end
      end
      drive_instr(c, err, 2, done_delay, 1'b1);
      total++; if (hung !== 1'b0 || obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand%0d_beats: got %0d hung=%b want %0d", n, obs_q.size(), hung, exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
        total++;
        if (obs_q[k].req !== exp_q[k].req || obs_q[k].op !== exp_q[k].op ||
            obs_q[k].comp !== exp_q[k].comp || obs_q[k].addr !== exp_q[k].addr) begin
          bad++;
          $display("FAIL rand%0d_beat%0d: got req=%b op=%0d comp=%0d addr=%0d want req=%b op=%0d comp=%0d addr=%0d",
                   n, k, obs_q[k].req, obs_q[k].op, obs_q[k].comp, obs_q[k].addr,
                   exp_q[k].req, exp_q[k].op, exp_q[k].comp, exp_q[k].addr);
        end
      end
      total++; if (wait_cycles != exp_wait) begin bad++; $display("FAIL rand%0d_wait: got %0d want %0d", n, wait_cycles, exp_wait); end
      total++; if (stab_err != 0 || req_err != 0) begin
        bad++; $display("FAIL rand%0d_hold: got stab=%0d req=%0d want 0 0", n, stab_err, req_err);
      end
      total++; if (issued_cnt !== 16'(exp_issued) || dropped_cnt !== 8'(exp_dropped) || timeout_flag !== exp_to) begin
        bad++; $display("FAIL rand%0d_counters: got issued=%0d dropped=%0d to=%b want %0d %0d %b",
                        n, issued_cnt, dropped_cnt, timeout_flag, exp_issued, exp_dropped, exp_to);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_load_wrap();
    test_comp_wait();
    test_back_to_back();
    test_store_toggle();
    test_timeout();
    test_reset_mid();
    test_dropped_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
